// File: rtl/csr_file.sv
// rtl/csr_file.sv - privileged CSR file: mode/exception state, interrupt status, timer, stable counter
module csr_file (
    input  logic        clk,
    input  logic        reset,
    input  logic        csr_re,
    input  logic [13:0] csr_num,
    output logic [31:0] csr_rvalue,
    input  logic        csr_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    input  logic        wb_ex,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_ex_pc,
    input  logic [31:0] wb_vaddr,
    input  logic        ertn_flush,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic        has_int,
    output logic [63:0] stable_counter,
    output logic [31:0] counter_id
);

    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ECFG   = 14'h004;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_BADV   = 14'h007;
    localparam logic [13:0] CSR_EENTRY = 14'h00c;
    localparam logic [13:0] CSR_TID    = 14'h040;
    localparam logic [13:0] CSR_TCFG   = 14'h041;
    localparam logic [13:0] CSR_TVAL   = 14'h042;
    localparam logic [13:0] CSR_TICLR  = 14'h044;
    localparam logic [13:0] CSR_TLBREN = 14'h088;
    localparam logic [12:0] LIE_MASK   = 13'h1bff;

    logic [1:0]  crmd_plv;
    logic        crmd_ie;
    logic        crmd_da;
    logic [1:0]  prmd_pplv;
    logic        prmd_pie;
    logic [12:0] ecfg_lie;
    logic [1:0]  is_sw;
    logic [7:0]  is_hw;
    logic        is_ti;
    logic        is_ipi;
    logic [5:0]  estat_ecode;
    logic [8:0]  estat_esubcode;
    logic [31:0] era;
    logic [31:0] badv;
    logic [25:0] eentry_va;
    logic [31:0] save [4];
    logic [31:0] tid;
    logic [31:0] tcfg;
    logic [31:0] tval;
    logic [25:0] tlbrentry_pa;

    logic [31:0] crmd_v, prmd_v, ecfg_v, estat_v;
    logic [12:0] estat_is;
    logic        unused_re;

    assign estat_is = {is_ipi, is_ti, 1'b0, is_hw, is_sw};
    assign crmd_v   = {28'b0, crmd_da, crmd_ie, crmd_plv};
    assign prmd_v   = {29'b0, prmd_pie, prmd_pplv};
    assign ecfg_v   = {19'b0, ecfg_lie};
    assign estat_v  = {1'b0, estat_esubcode, estat_ecode, 3'b0, estat_is};
    assign unused_re = csr_re;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] m,
                                          input logic [31:0] v);
        return (old & ~m) | (v & m);
    endfunction

    logic [31:0] crmd_m, prmd_m, tcfg_m;
    logic        we_crmd, we_prmd, we_ecfg, we_estat, we_era, we_badv;
    logic        we_eentry, we_save, we_tid, we_tcfg, we_tlbren, ticlr_clr;

    assign crmd_m    = merge(crmd_v, csr_wmask, csr_wvalue);
    assign prmd_m    = merge(prmd_v, csr_wmask, csr_wvalue);
    assign tcfg_m    = merge(tcfg, csr_wmask, csr_wvalue);
    assign we_crmd   = csr_we && (csr_num == CSR_CRMD);
    assign we_prmd   = csr_we && (csr_num == CSR_PRMD);
    assign we_ecfg   = csr_we && (csr_num == CSR_ECFG);
    assign we_estat  = csr_we && (csr_num == CSR_ESTAT);
    assign we_era    = csr_we && (csr_num == CSR_ERA);
    assign we_badv   = csr_we && (csr_num == CSR_BADV);
    assign we_eentry = csr_we && (csr_num == CSR_EENTRY);
    assign we_save   = csr_we && (csr_num[13:2] == 12'd12);
    assign we_tid    = csr_we && (csr_num == CSR_TID);
    assign we_tcfg   = csr_we && (csr_num == CSR_TCFG);
    assign we_tlbren = csr_we && (csr_num == CSR_TLBREN);
    assign ticlr_clr = csr_we && (csr_num == CSR_TICLR) && csr_wmask[0] && csr_wvalue[0];

    always_comb begin
        csr_rvalue = 32'b0;
        case (csr_num)
            CSR_CRMD:   csr_rvalue = crmd_v;
            CSR_PRMD:   csr_rvalue = prmd_v;
            CSR_ECFG:   csr_rvalue = ecfg_v;
            CSR_ESTAT:  csr_rvalue = estat_v;
            CSR_ERA:    csr_rvalue = era;
            CSR_BADV:   csr_rvalue = badv;
            CSR_EENTRY: csr_rvalue = {eentry_va, 6'b0};
            14'h030, 14'h031, 14'h032, 14'h033: csr_rvalue = save[csr_num[1:0]];
            CSR_TID:    csr_rvalue = tid;
            CSR_TCFG:   csr_rvalue = tcfg;
            CSR_TVAL:   csr_rvalue = tval;
            CSR_TLBREN: csr_rvalue = {tlbrentry_pa, 6'b0};
            default:    csr_rvalue = 32'b0;
        endcase
    end

    assign has_int    = crmd_ie & |(estat_is & ecfg_lie);
    assign counter_id = tid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crmd_plv       <= 2'b0;
            crmd_ie        <= 1'b0;
            crmd_da        <= 1'b1;
            prmd_pplv      <= 2'b0;
            prmd_pie       <= 1'b0;
            ecfg_lie       <= 13'b0;
            is_sw          <= 2'b0;
            is_hw          <= 8'b0;
            is_ti          <= 1'b0;
            is_ipi         <= 1'b0;
            estat_ecode    <= 6'b0;
            estat_esubcode <= 9'b0;
            era            <= 32'b0;
            badv           <= 32'b0;
            eentry_va      <= 26'b0;
            for (int i = 0; i < 4; i++) save[i] <= 32'b0;
            tid            <= 32'b0;
            tcfg           <= 32'b0;
            tval           <= 32'b0;
            tlbrentry_pa   <= 26'b0;
            stable_counter <= 64'b0;
        end else begin
            stable_counter <= stable_counter + 64'd1;

            // Mode fields: exception entry beats ertn beats software write.
            if (wb_ex) begin
                crmd_plv <= 2'b0;
                crmd_ie  <= 1'b0;
            end else if (ertn_flush) begin
                crmd_plv <= prmd_pplv;
                crmd_ie  <= prmd_pie;
            end else if (we_crmd) begin
                crmd_plv <= crmd_m[1:0];
                crmd_ie  <= crmd_m[2];
            end
            if (we_crmd) crmd_da <= crmd_m[3];

            if (wb_ex) begin
                prmd_pplv <= crmd_plv;
                prmd_pie  <= crmd_ie;
            end else if (we_prmd) begin
                prmd_pplv <= prmd_m[1:0];
                prmd_pie  <= prmd_m[2];
            end

            if (we_ecfg) ecfg_lie <= merge(ecfg_v, csr_wmask, csr_wvalue) & LIE_MASK;
            if (we_estat) is_sw <= merge(estat_v, csr_wmask, csr_wvalue) & 2'b11;
            is_hw  <= hw_int_in;
            is_ipi <= ipi_int_in;
            if (tcfg[0] && tval == 32'b0) is_ti <= 1'b1;
            else if (ticlr_clr)           is_ti <= 1'b0;

            if (wb_ex) begin
                estat_ecode    <= wb_ecode;
                estat_esubcode <= wb_esubcode;
                era            <= wb_ex_pc;
            end else if (we_era) begin
                era <= merge(era, csr_wmask, csr_wvalue);
            end

            if (wb_ex && wb_ecode == 6'h08)                          badv <= wb_ex_pc;
            else if (wb_ex && (wb_ecode == 6'h09 || wb_ecode == 6'h3f)) badv <= wb_vaddr;
            else if (we_badv) badv <= merge(badv, csr_wmask, csr_wvalue);

            if (we_eentry) eentry_va <= merge({eentry_va, 6'b0}, csr_wmask, csr_wvalue) >> 6;
            if (we_tlbren) tlbrentry_pa <= merge({tlbrentry_pa, 6'b0}, csr_wmask, csr_wvalue) >> 6;
            if (we_save) save[csr_num[1:0]] <= merge(save[csr_num[1:0]], csr_wmask, csr_wvalue);
            if (we_tid) tid <= merge(tid, csr_wmask, csr_wvalue);

            // A one-shot countdown parks at all-ones, which also freezes it.
            if (we_tcfg) begin
                tcfg <= tcfg_m;
                tval <= {tcfg_m[31:2], 2'b00};
            end else if (tcfg[0] && tval != 32'hffffffff) begin
                if (tval == 32'b0 && tcfg[1]) tval <= {tcfg[31:2], 2'b00};
                else                          tval <= tval - 32'd1;
            end
        end
    end

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on posedge clk.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-high; one clock; this polarity and synchronicity are fixed.
REQ-003 SHALL have ports csr_re in 1, csr_num in 14, and csr_rvalue out 32: the read port.
REQ-004 SHALL have ports csr_we in 1, csr_wmask in 32, and csr_wvalue in 32: the masked write port.
REQ-005 SHALL have ports wb_ex in 1, wb_ecode in 6, wb_esubcode in 9, wb_ex_pc in 32, and wb_vaddr in 32: exception commit from WB.
REQ-006 SHALL have port ertn_flush, input, 1: ertn commit.
REQ-007 SHALL have ports hw_int_in in 8 and ipi_int_in in 1: external interrupt levels.
REQ-008 SHALL have port has_int, out 1: interrupt pending and enabled.
REQ-009 SHALL have ports stable_counter out 64 and counter_id out 32: rdcnt sources.

Function
REQ-010 SHALL implement these registers (csr_num, hex):
- CRMD 0: PLV[1:0], IE[2], DA[3]
- PRMD 1: PPLV[1:0], PIE[2]
- ECFG 4: LIE[12:0], excluding bit 10
- ESTAT 5: IS[12:0], Ecode[21:16], EsubCode[30:22]
- ERA 6, BADV 7, EENTRY c with [5:0] read as 0
- SAVE0-3 30-33, TID 40
- TCFG 41: En[0], Periodic[1], InitVal[31:2]
- TVAL 42 (read-only), TICLR 44 (reads 0), TLBRENTRY 88 with [5:0] read as 0
REQ-011 SHALL drive csr_rvalue combinationally from csr_num regardless of csr_re; unmapped numbers and reserved bits read 0.
REQ-012 SHALL, when csr_we=1 at posedge, update each writable field to (old & ~csr_wmask) | (csr_wvalue & csr_wmask); only IS[1:0] of ESTAT is software-writable.
REQ-013 SHALL, when wb_ex=1 at posedge, update state as follows:
- PRMD.PPLV<=CRMD.PLV; PRMD.PIE<=CRMD.IE
- CRMD.PLV<=0; CRMD.IE<=0
- ERA<=wb_ex_pc
- ESTAT.Ecode<=wb_ecode; ESTAT.EsubCode<=wb_esubcode
REQ-014 SHALL, on wb_ex, load BADV<=wb_ex_pc for Ecode 0x08 (ADEF), and BADV<=wb_vaddr for Ecode 0x09 (ALE) and 0x3f (TLBR); BADV SHALL be unchanged for other codes.
REQ-015 SHALL, when ertn_flush=1 at posedge, load CRMD.PLV<=PRMD.PPLV and CRMD.IE<=PRMD.PIE.
REQ-016 SHALL give priority wb_ex > ertn_flush > csr_we on any conflicting field in the same cycle; non-conflicting csr_we fields still apply.
REQ-017 SHALL sample IS[9:2]<=hw_int_in and IS[12]<=ipi_int_in every cycle.
REQ-018 SHALL, on a TCFG write, also load TVAL<={new InitVal,2'b00} in the same edge.
REQ-019 SHALL, otherwise, when TCFG.En=1 and TVAL!=32'hffffffff, update TVAL as follows:
- TVAL==0 and Periodic=1: reload {InitVal,2'b00}
- else: TVAL<=TVAL-1, so one-shot wraps to ffffffff and stops
REQ-020 SHALL set IS[11] on the cycle TCFG.En=1 and TVAL==0.
REQ-021 SHALL clear IS[11] on a TICLR write with csr_wmask[0]&csr_wvalue[0]=1; set wins if coincident.
REQ-022 SHALL drive has_int = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]), combinationally.
REQ-023 SHALL increment stable_counter by 1 every cycle, wrapping at 2^64; counter_id SHALL equal TID.

Reset
REQ-024 SHALL, while reset=1, asynchronously force CRMD=32'h8 (DA=1), all other registers 0, TVAL=0, and stable_counter=0; has_int SHALL therefore be 0.
REQ-025 SHALL hold no in-flight operation across reset; first update occurs on the first posedge after reset deasserts.

Verification
REQ-026 SHALL cover masked write: SAVE0=0x12345678, then write wvalue=0xffffffff with mask=0x0000ff00 -> read SAVE0=0x1234ff78.
REQ-027 SHALL cover exception then ertn:
- Stimulus: CRMD PLV=3, IE=1; wb_ex with ecode=0x08, pc=0x1c000100
- Required: CRMD PLV=0, IE=0; PRMD=0x7; ERA=0x1c000100; BADV=0x1c000100; Ecode=0x08
- Then ertn_flush -> CRMD PLV=3, IE=1
REQ-028 SHALL cover one-shot timer:
- Stimulus: TCFG=0x9 (InitVal=2, En=1)
- Required: TVAL=8,7,...,0, then IS[11]=1 and TVAL=ffffffff held
- With LIE[11]=1 and IE=1 -> has_int=1
- Then TICLR write 1 -> IS[11]=0, has_int=0
REQ-029 SHALL cover periodic timer: TCFG=0xb -> TVAL reloads 8 after reaching 0; IS[11] sets every 9 cycles.
REQ-030 SHALL cover conflict: same-cycle wb_ex and csr_we to CRMD with PLV=2 -> CRMD.PLV=0.
REQ-031 SHALL cover reset: assert reset mid-count -> TVAL=0, CRMD=0x8, and stable_counter=0 immediately, without waiting for a clock edge.
